// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector event counter.
package seq_pkg;

    // Detector-output tracking FSM, minimum encoding.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam int         COUNT_MAX = 99;
    localparam int         RUN_W_DEF = 4;

    // Binary value of a two-digit BCD number.
    function automatic int bcd_value(input logic [3:0] tens, input logic [3:0] ones);
        return int'(tens) * 10 + int'(ones);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register; wraps 9 -> 0 and flags the wrap as carry.
module bcd_digit
    import seq_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output logic [3:0] digit,
    output logic       carry
);

    logic step;

    assign step  = inc && !hold;
    assign carry = step && (digit == BCD_MAX);

    // Digit register: reset and clear zero it, an unheld increment advances it.
    always_ff @(posedge Clock) begin
        if (Reset || clr)
            digit <= 4'd0;
        else if (step)
            digit <= carry ? 4'd0 : digit + 4'd1;
    end

endmodule

// File: rtl/seq_event_counter.sv
// Counts rising edges of the detector output z (2-digit BCD, saturating at
// 99 with a sticky overflow) and measures current and longest z-high runs.
module seq_event_counter
    import seq_pkg::*;
#(
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             z,
    output logic             event_pulse,
    output logic [3:0]       count_ones,
    output logic [3:0]       count_tens,
    output logic             overflow,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] max_run,
    output logic             state
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    seq_state_t       cur_st, nxt_st;
    logic             edge_evt;
    logic             at_max;
    logic             ones_carry;
    logic             unused_tens_carry;
    logic             run_upd;
    logic [RUN_W-1:0] run_nxt;
    logic [RUN_W-1:0] max_nxt;

    // Next state: the FSM simply remembers the last sample of z.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE:    nxt_st = z ? RUN : IDLE;
            RUN:     nxt_st = z ? RUN : IDLE;
            default: nxt_st = IDLE;
        endcase
    end

    // State register; Clear intentionally leaves the edge history alone.
    always_ff @(posedge Clock) begin
        if (Reset)
            cur_st <= IDLE;
        else
            cur_st <= nxt_st;
    end

    assign edge_evt = (cur_st == IDLE) && z;
    assign at_max   = (bcd_value(count_tens, count_ones) == COUNT_MAX);
    assign state    = cur_st;

    // Event pulse is registered and still fires when Clear coincides.
    always_ff @(posedge Clock) begin
        if (Reset)
            event_pulse <= 1'b0;
        else
            event_pulse <= edge_evt;
    end

    // Ones chained into tens; both held once the count reaches 99.
    bcd_digit u_ones (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (Clear),
        .inc   (edge_evt),
        .hold  (at_max),
        .digit (count_ones),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (Clear),
        .inc   (ones_carry),
        .hold  (at_max),
        .digit (count_tens),
        .carry (unused_tens_carry)
    );

    // Sticky overflow when an event arrives with the count already at 99.
    always_ff @(posedge Clock) begin
        if (Reset || Clear)
            overflow <= 1'b0;
        else if (edge_evt && at_max)
            overflow <= 1'b1;
    end

    // Run-length update: restart at 1 on an edge, saturating increment while high.
    always_comb begin
        run_upd = 1'b0;
        run_nxt = run_len;
        if (edge_evt) begin
            run_upd = 1'b1;
            run_nxt = {{(RUN_W-1){1'b0}}, 1'b1};
        end else if ((cur_st == RUN) && z) begin
            run_upd = 1'b1;
            run_nxt = (run_len == RUN_MAX) ? run_len : run_len + 1'b1;
        end
        max_nxt = (run_nxt > max_run) ? run_nxt : max_run;
    end

    // Run-length and longest-run registers; they hold whenever z is low.
    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            run_len <= '0;
            max_run <= '0;
        end else if (run_upd) begin
            run_len <= run_nxt;
            max_run <= max_nxt;
        end
    end

endmodule

// File: tb/tb_seq_event_counter.sv
// Directed bench: stimulus queues expected event snapshots, a monitor checks
// them whenever event_pulse is seen; static state is checked between steps.
module tb_seq_event_counter;

    typedef struct {
        int         cyc;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
        logic [3:0] rl;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Clear = 1'b0;
    logic       z     = 1'b0;
    logic       event_pulse;
    logic [3:0] count_ones, count_tens;
    logic       overflow;
    logic [3:0] run_len, max_run;
    logic       state;

    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    exp_t q[$];

    seq_event_counter #(.RUN_W(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Clear       (Clear),
        .z           (z),
        .event_pulse (event_pulse),
        .count_ones  (count_ones),
        .count_tens  (count_tens),
        .overflow    (overflow),
        .run_len     (run_len),
        .max_run     (max_run),
        .state       (state)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs and return just after the sampling edge.
    task automatic step(input logic zv, input logic clr = 1'b0, input logic rst = 1'b0);
        z = zv; Clear = clr; Reset = rst;
        @(posedge Clock);
        #1;
    endtask

    // Called just before the step whose sample should create an event.
    task automatic expect_ev(input int tens, input int ones, input logic ovf, input int rl);
        exp_t e;
        e.cyc  = cyc + 1;
        e.tens = 4'(tens);
        e.ones = 4'(ones);
        e.ovf  = ovf;
        e.rl   = 4'(rl);
        q.push_back(e);
    endtask

    // Monitor: every observed event pulse must match the next queued expectation.
    always @(negedge Clock) begin
        if (event_pulse === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_tens", int'(count_tens), int'(e.tens));
                chk("ev_ones", int'(count_ones), int'(e.ones));
                chk("ev_ovf", int'(overflow), int'(e.ovf));
                chk("ev_run_len", int'(run_len), int'(e.rl));
            end
        end
    end

    initial begin
        // Reset, then idle
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (5) step(0);
        chk("rst_pulse", int'(event_pulse), 0);
        chk("rst_ones", int'(count_ones), 0);
        chk("rst_tens", int'(count_tens), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_run_len", int'(run_len), 0);
        chk("rst_max_run", int'(max_run), 0);
        chk("rst_state", int'(state), 0);

        // Three-cycle run
        expect_ev(0, 1, 0, 1);
        repeat (3) step(1);
        chk("run3_state", int'(state), 1);
        chk("run3_len_high", int'(run_len), 3);
        step(0);
        chk("run3_state_low", int'(state), 0);
        chk("run3_len", int'(run_len), 3);
        chk("run3_max", int'(max_run), 3);
        step(0);
        chk("run3_len_hold", int'(run_len), 3);

        // Twelve single-cycle pulses after a clear
        step(0, 1);
        for (int i = 1; i <= 12; i++) begin
            expect_ev(i / 10, i % 10, 0, 1);
            step(1);
            step(0);
        end
        chk("p12_tens", int'(count_tens), 1);
        chk("p12_ones", int'(count_ones), 2);
        chk("p12_run_len", int'(run_len), 1);
        chk("p12_max_run", int'(max_run), 1);

        // 101 events: count saturates at 99, overflow from event 100
        step(0, 1);
        for (int i = 1; i <= 101; i++) begin
            int c;
            c = (i > 99) ? 99 : i;
            expect_ev(c / 10, c % 10, (i >= 100), 1);
            step(1);
            step(0);
        end
        chk("sat_tens", int'(count_tens), 9);
        chk("sat_ones", int'(count_ones), 9);
        chk("sat_ovf", int'(overflow), 1);
        step(0, 1);
        chk("clr_tens", int'(count_tens), 0);
        chk("clr_ones", int'(count_ones), 0);
        chk("clr_ovf", int'(overflow), 0);

        // Run-length saturation at 15, then a short run
        expect_ev(0, 1, 0, 1);
        repeat (20) step(1);
        chk("long_run_len", int'(run_len), 15);
        chk("long_max_run", int'(max_run), 15);
        step(0);
        expect_ev(0, 2, 0, 1);
        repeat (2) step(1);
        chk("short_run_len", int'(run_len), 2);
        chk("short_max_run", int'(max_run), 15);
        step(0);

        // Clear coincident with a rising edge: pulse still fires, counters zero
        expect_ev(0, 0, 0, 0);
        step(1, 1);
        chk("coin_ones", int'(count_ones), 0);
        step(1);
        chk("coin_run_len", int'(run_len), 1);
        chk("coin_max_run", int'(max_run), 1);
        step(0);

        // Reset mid-run, released while z is still high
        step(0, 1);
        expect_ev(0, 1, 0, 1);
        step(1);
        step(1);
        step(1, 0, 1);
        step(1, 0, 1);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_ones", int'(count_ones), 0);
        chk("mid_rst_run_len", int'(run_len), 0);
        expect_ev(0, 1, 0, 1);
        step(1);
        chk("post_rst_ones", int'(count_ones), 1);
        chk("post_rst_state", int'(state), 1);
        step(0);
        repeat (3) step(0);

        chk("events_outstanding", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
